nim_game: RTL

NIM_GAME -- requirements
Module: nim_game

---
 rtl/nim_pkg.sv | 33 +++
 rtl/nim_strategy.sv | 123 ++++++++++++
 rtl/nim_game.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/nim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nim_pkg
// Brief    : Shared state encoding and move helper for the Nim game block.
//            NIM_MISERE_EN selects misere play (taker of the last counter loses).
// Revision : 1.0 - initial release
// ============================================================================
package nim_pkg;

  // FSM state encoding shared by the game controller and its test bench
  typedef logic [1:0] nim_state_t;

  localparam nim_state_t c_st_load = 2'd0;
  localparam nim_state_t c_st_env  = 2'd1;
  localparam nim_state_t c_st_sys  = 2'd2;
  localparam nim_state_t c_st_done = 2'd3;

  // Play mode: outcome when a side is left facing all-empty piles
`ifdef NIM_MISERE_EN
  localparam logic c_misere = 1'b1;
`else
  localparam logic c_misere = 1'b0;
`endif

  // A pile is a candidate for the XOR move when folding the nim-sum
  // into it strictly shrinks it (i.e. the move removes counters).
  function automatic logic reduces_pile(input logic [31:0] pile,
                                        input logic [31:0] nimsum);
    return (pile ^ nimsum) < pile;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nim_strategy.sv
`default_nettype none
// ============================================================================
// Module   : nim_strategy
// Brief    : Combinational position evaluator. Takes all pile counts and
//            returns the system's chosen move plus a "mover wins" flag.
//            NIM_MISERE_EN adds the misere end-game rules on top of the
//            XOR / first-fit strategy.
// Revision : 1.0 - initial release
// ============================================================================
module nim_strategy
  import nim_pkg::*;
#(
  parameter int NPILE = 4,
  parameter int CNTW  = 4,
  parameter int COLW  = $clog2(NPILE)
) (
  input  logic [NPILE*CNTW-1:0] piles,
  output logic [COLW-1:0]       move_col,
  output logic [CNTW-1:0]       move_num,
  output logic                  mover_wins,
  output logic                  all_empty
);

  logic [CNTW-1:0] w_p [NPILE];
  logic [CNTW-1:0] w_x;
  logic [COLW-1:0] w_n_col;
  logic [CNTW-1:0] w_n_num;
  logic            w_found;

  // Unpack the flat pile bus into an indexable array
  for (genvar gi = 0; gi < NPILE; gi++) begin : g_unpack
    assign w_p[gi] = piles[gi*CNTW +: CNTW];
  end

  // Nim-sum of all piles and the empty-board detector
  always_comb begin
    w_x       = '0;
    all_empty = 1'b1;
    for (int i = 0; i < NPILE; i++) begin
      w_x = w_x ^ w_p[i];
      if (w_p[i] != '0) all_empty = 1'b0;
    end
  end

  // Normal-play move: reach a zero nim-sum if possible, else stall by one
  always_comb begin
    w_n_col = '0;
    w_n_num = '0;
    w_found = 1'b0;
    if (w_x != '0) begin
      for (int i = 0; i < NPILE; i++) begin
        if (!w_found && reduces_pile(32'(w_p[i]), 32'(w_x))) begin
          w_found = 1'b1;
          w_n_col = COLW'(i);
          w_n_num = w_p[i] - (w_p[i] ^ w_x);
        end
      end
    end else begin
      for (int i = 0; i < NPILE; i++) begin
        if (!w_found && (w_p[i] != '0)) begin
          w_found = 1'b1;
          w_n_col = COLW'(i);
          w_n_num = CNTW'(1);
        end
      end
    end
  end

`ifdef NIM_MISERE_EN
  localparam int CNTN = COLW + 1;

  logic [CNTN-1:0] w_nbig;
  logic [CNTN-1:0] w_nones;
  logic [COLW-1:0] w_big_col;
  logic [CNTW-1:0] w_big_val;
  logic [COLW-1:0] w_one_col;
  logic            w_one_found;

  // Census of piles larger than one and of single-counter piles
  always_comb begin
    w_nbig      = '0;
    w_nones     = '0;
    w_big_col   = '0;
    w_big_val   = '0;
    w_one_col   = '0;
    w_one_found = 1'b0;
    for (int i = 0; i < NPILE; i++) begin
      if (w_p[i] > CNTW'(1)) begin
        w_nbig    = w_nbig + CNTN'(1);
        w_big_col = COLW'(i);
        w_big_val = w_p[i];
      end else if (w_p[i] == CNTW'(1)) begin
        w_nones = w_nones + CNTN'(1);
        if (!w_one_found) begin
          w_one_found = 1'b1;
          w_one_col   = COLW'(i);
        end
      end
    end
  end
`endif

  // Final move selection; misere end-game overrides the XOR move
  always_comb begin
    move_col   = w_n_col;
    move_num   = w_n_num;
    mover_wins = (w_x != '0);
`ifdef NIM_MISERE_EN
    if (w_nbig == CNTN'(1)) begin
      // Leave an odd number of single-counter piles behind
      move_col   = w_big_col;
      move_num   = w_nones[0] ? w_big_val : (w_big_val - CNTW'(1));
      mover_wins = 1'b1;
    end else if (w_nbig == '0) begin
      move_col   = w_one_col;
      move_num   = w_one_found ? CNTW'(1) : '0;
      mover_wins = ~w_nones[0];
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/nim_game.sv
`default_nettype none
// ============================================================================
// Module   : nim_game
// Brief    : Nim game controller. Loads pile counts, validates environment
//            moves, answers each legal move with a system move and reports
//            the outcome. NIM_MISERE_EN selects misere play.
// Revision : 1.0 - initial release
// ============================================================================
module nim_game
  import nim_pkg::*;
#(
  parameter int NPILE = 4,
  parameter int CNTW  = 4,
  parameter int COLW  = $clog2(NPILE)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [COLW-1:0] col,
  input  logic [CNTW-1:0] num,
  output logic            sys_valid,
  output logic [COLW-1:0] sys_col,
  output logic [CNTW-1:0] sys_num,
  output logic            illegal,
  output logic            winning,
  output logic            win,
  output logic            lose
);

  nim_state_t              r_state;
  logic [COLW-1:0]         r_k;
  logic [CNTW-1:0]         r_pile [NPILE];
  logic                    r_env_won;

  logic [NPILE*CNTW-1:0]   w_piles_flat;
  logic [COLW-1:0]         w_move_col;
  logic [CNTW-1:0]         w_move_num;
  logic                    w_mover_wins;
  logic                    w_all_empty;
  logic                    w_hs;
  logic                    w_col_ok;
  logic [CNTW-1:0]         w_sel;
  logic                    w_legal;
  logic                    w_env_take;

  // Flatten the pile registers for the strategy evaluator
  for (genvar gi = 0; gi < NPILE; gi++) begin : g_flat
    assign w_piles_flat[gi*CNTW +: CNTW] = r_pile[gi];
  end

  nim_strategy #(
    .NPILE (NPILE),
    .CNTW  (CNTW),
    .COLW  (COLW)
  ) u_strategy (
    .piles      (w_piles_flat),
    .move_col   (w_move_col),
    .move_num   (w_move_num),
    .mover_wins (w_mover_wins),
    .all_empty  (w_all_empty)
  );

  // Handshake and environment-move legality
  always_comb begin
    in_ready   = (r_state == c_st_load) || (r_state == c_st_env);
    w_hs       = in_valid && in_ready;
    w_col_ok   = 32'(col) < NPILE;
    w_sel      = w_col_ok ? r_pile[col] : '0;
    w_legal    = w_col_ok && (num != '0) && (num <= w_sel);
    w_env_take = (r_state == c_st_env) && w_hs && w_legal && !w_all_empty;
  end

  // Status outputs; move fields read as zero unless the move is presented
  always_comb begin
    sys_valid = (r_state == c_st_sys) && !w_all_empty;
    sys_col   = sys_valid ? w_move_col : '0;
    sys_num   = sys_valid ? w_move_num : '0;
    illegal   = (r_state == c_st_env) && w_hs && !w_legal && !w_all_empty;
    winning   = (r_state == c_st_env) && w_mover_wins;
    win       = (r_state == c_st_done) && r_env_won;
    lose      = (r_state == c_st_done) && !r_env_won;
  end

  // Game sequencing: load beats, environment turn, system turn, result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_st_load;
      r_k       <= '0;
      r_env_won <= 1'b0;
    end else begin
      case (r_state)
        c_st_load: begin
          if (w_hs) begin
            if (r_k == COLW'(NPILE - 1)) begin
              r_k     <= '0;
              r_state <= c_st_env;
            end else begin
              r_k <= r_k + COLW'(1);
            end
          end
        end
        c_st_env: begin
          if (w_all_empty) begin
            // Environment faces an empty board: normal loses, misere wins
            r_env_won <= c_misere;
            r_state   <= c_st_done;
          end else if (w_env_take) begin
            r_state <= c_st_sys;
          end
        end
        c_st_sys: begin
          if (w_all_empty) begin
            // Environment took the last counter
            r_env_won <= ~c_misere;
            r_state   <= c_st_done;
          end else begin
            r_state <= c_st_env;
          end
        end
        default: begin
          if (start) begin
            r_k     <= '0;
            r_state <= c_st_load;
          end
        end
      endcase
    end
  end

  // Pile storage: load beats, legal environment moves, system moves
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPILE; i++) r_pile[i] <= '0;
    end else if ((r_state == c_st_load) && w_hs) begin
      r_pile[r_k] <= num;
    end else if (w_env_take) begin
      r_pile[col] <= w_sel - num;
    end else if (sys_valid) begin
      r_pile[w_move_col] <= r_pile[w_move_col] - w_move_num;
    end
  end

endmodule
`default_nettype wire
